// File: rtl/reg_write_scheduler_pkg.sv
// Shared types and defaults for the register-bank write scheduler.
// Requester IDs double as the round-robin "last served" encoding.
package reg_write_scheduler_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_AW     = 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

endpackage

// File: rtl/reg_write_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter with combinational grants; reusable for any
// pair of requesters sharing one port.
module rr_arbiter2
  import reg_write_scheduler_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  req_id_t rr_last;

  // On contention the requester not served last wins; reset favours A.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (enable) begin
      if (req_a && (!req_b || rr_last == REQ_B)) begin
        gnt_a = 1'b1;
      end else if (req_b) begin
        gnt_b = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last <= REQ_B;
    end else if (gnt_a) begin
      rr_last <= REQ_A;
    end else if (gnt_b) begin
      rr_last <= REQ_B;
    end
  end

endmodule

// File: rtl/reg_write_scheduler.sv
// Write-port scheduler for a reset-less register bank: clears every register
// after reset, then shares the single write path between requesters A and B.
module reg_write_scheduler
  import reg_write_scheduler_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREG   = 4,
  parameter int AW     = DEF_AW
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              a_req,
  input  logic [AW-1:0]     a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_gnt,
  input  logic              b_req,
  input  logic [AW-1:0]     b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_gnt,
  output logic [NREG-1:0]   wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              init_done
);

  state_t            state;
  state_t            state_next;
  logic [AW-1:0]     init_idx;
  logic              init_last;
  logic              run;
  logic              sel_valid;
  logic [AW-1:0]     sel_addr;
  logic [DATA_W-1:0] sel_data;

  assign run       = (state == ST_RUN);
  assign init_last = (state == ST_INIT) && (init_idx == AW'(NREG - 1));

  rr_arbiter2 u_arb (
    .clk    (CLK),
    .rst    (RST),
    .enable (run),
    .req_a  (a_req),
    .req_b  (b_req),
    .gnt_a  (a_gnt),
    .gnt_b  (b_gnt)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_INIT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (init_last) begin
      state_next = ST_RUN;
    end
  end

  // During INIT the write source is the clearing sequence, otherwise the winner.
  always_comb begin
    sel_valid = 1'b0;
    sel_addr  = init_idx;
    sel_data  = '0;
    case (state)
      ST_INIT: sel_valid = 1'b1;
      ST_RUN: begin
        if (a_gnt) begin
          sel_valid = 1'b1;
          sel_addr  = a_addr;
          sel_data  = a_data;
        end else if (b_gnt) begin
          sel_valid = 1'b1;
          sel_addr  = b_addr;
          sel_data  = b_data;
        end
      end
      default: sel_valid = 1'b0;
    endcase
  end

  // With no write, only the enables drop; address and data hold.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_en     <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      init_idx  <= '0;
      init_done <= 1'b0;
    end else begin
      if (sel_valid) begin
        wr_en   <= NREG'(1) << sel_addr;
        wr_addr <= sel_addr;
        wr_data <= sel_data;
      end else begin
        wr_en <= '0;
      end
      if (state == ST_INIT) begin
        init_idx <= init_idx + AW'(1);
      end
      if (init_last) begin
        init_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_write_scheduler.sv
// Bench for reg_write_scheduler: directed init/reset sequences, a vector table
// for arbitration cases, and randomized traffic against a behavioural model.
module tb_reg_write_scheduler;

  localparam int DATA_W = 16;
  localparam int NREG   = 4;
  localparam int AW     = 2;

  logic              CLK = 1'b0;
  logic              RST;
  logic              a_req, b_req;
  logic [AW-1:0]     a_addr, b_addr;
  logic [DATA_W-1:0] a_data, b_data;
  logic              a_gnt, b_gnt;
  logic [NREG-1:0]   wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              init_done;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic              ar;
    logic [AW-1:0]     aa;
    logic [DATA_W-1:0] ad;
    logic              br;
    logic [AW-1:0]     ba;
    logic [DATA_W-1:0] bd;
    logic              ga;
    logic              gb;
    logic [NREG-1:0]   en;
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] data;
  } vec_t;

  vec_t vecs[12];

  // Behavioural model: clears issued so far, who was served last, expected
  // registered outputs and the expected bank contents.
  int                m_init_cnt;
  bit                m_done;
  bit                m_last_b;
  logic [NREG-1:0]   m_wr_en;
  logic [AW-1:0]     m_wr_addr;
  logic [DATA_W-1:0] m_wr_data;
  logic [DATA_W-1:0] exp_bank[NREG];
  logic [DATA_W-1:0] obs_bank[NREG];
  bit                last_ga, last_gb;

  reg_write_scheduler #(.DATA_W(DATA_W), .NREG(NREG), .AW(AW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .a_req     (a_req),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .a_gnt     (a_gnt),
    .b_req     (b_req),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .b_gnt     (b_gnt),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .init_done (init_done)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic ar, input logic [AW-1:0] aa, input logic [DATA_W-1:0] ad,
                               input logic br, input logic [AW-1:0] ba, input logic [DATA_W-1:0] bd);
    a_req = ar; a_addr = aa; a_data = ad;
    b_req = br; b_addr = ba; b_data = bd;
  endtask

  task automatic modelReset();
    m_init_cnt = 0;
    m_done     = 1'b0;
    m_last_b   = 1'b1;
    m_wr_en    = '0;
    m_wr_addr  = '0;
    m_wr_data  = '0;
    last_ga    = 1'b0;
    last_gb    = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      exp_bank[i] = '0;
      obs_bank[i] = '0;
    end
  endtask

  // Asynchronous pulse placed between clock edges; outputs must clear at once.
  task automatic resetPulse();
    #1 RST = 1'b1;
    #1;
    checkOutput("rst_wr_en", 32'(wr_en), 32'h0);
    checkOutput("rst_wr_addr", 32'(wr_addr), 32'h0);
    checkOutput("rst_wr_data", 32'(wr_data), 32'h0);
    checkOutput("rst_init_done", 32'(init_done), 32'h0);
    checkOutput("rst_a_gnt", 32'(a_gnt), 32'h0);
    checkOutput("rst_b_gnt", 32'(b_gnt), 32'h0);
    #1 RST = 1'b0;
    modelReset();
  endtask

  task automatic stepCycle();
    logic ga, gb;
    @(negedge CLK);
    ga = 1'b0;
    gb = 1'b0;
    if (m_done) begin
      if (a_req && b_req) begin
        ga = m_last_b;
        gb = !m_last_b;
      end else begin
        ga = a_req;
        gb = b_req;
      end
    end
    checkOutput("rnd_a_gnt", 32'(a_gnt), 32'(ga));
    checkOutput("rnd_b_gnt", 32'(b_gnt), 32'(gb));
    checkOutput("rnd_wr_en", 32'(wr_en), 32'(m_wr_en));
    checkOutput("rnd_wr_addr", 32'(wr_addr), 32'(m_wr_addr));
    checkOutput("rnd_wr_data", 32'(wr_data), 32'(m_wr_data));
    checkOutput("rnd_init_done", 32'(init_done), 32'(m_done));
    if (!m_done) begin
      m_wr_en = '0;
      m_wr_en[m_init_cnt] = 1'b1;
      m_wr_addr = AW'(m_init_cnt);
      m_wr_data = '0;
      exp_bank[m_init_cnt] = '0;
      m_init_cnt++;
      if (m_init_cnt == NREG) m_done = 1'b1;
    end else if (ga || gb) begin
      m_wr_addr = ga ? a_addr : b_addr;
      m_wr_data = ga ? a_data : b_data;
      m_wr_en = '0;
      m_wr_en[m_wr_addr] = 1'b1;
      exp_bank[m_wr_addr] = m_wr_data;
      m_last_b = gb;
    end else begin
      m_wr_en = '0;
    end
    last_ga = ga;
    last_gb = gb;
    @(posedge CLK);
    #1;
    for (int i = 0; i < NREG; i++) begin
      if (wr_en[i]) obs_bank[i] = wr_data;
    end
  endtask

  initial begin
    RST = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);

    vecs[0]  = '{1'b1, 2'd1, 16'h00AA, 1'b1, 2'd3, 16'h00BB, 1'b1, 1'b0, 4'b0010, 2'd1, 16'h00AA};
    vecs[1]  = '{1'b1, 2'd1, 16'h00AA, 1'b1, 2'd3, 16'h00BB, 1'b0, 1'b1, 4'b1000, 2'd3, 16'h00BB};
    vecs[2]  = '{1'b1, 2'd1, 16'h00AA, 1'b1, 2'd3, 16'h00BB, 1'b1, 1'b0, 4'b0010, 2'd1, 16'h00AA};
    vecs[3]  = '{1'b1, 2'd1, 16'h00AA, 1'b1, 2'd3, 16'h00BB, 1'b0, 1'b1, 4'b1000, 2'd3, 16'h00BB};
    vecs[4]  = '{1'b1, 2'd0, 16'h1111, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 4'b0001, 2'd0, 16'h1111};
    vecs[5]  = '{1'b1, 2'd0, 16'h1111, 1'b1, 2'd0, 16'h2222, 1'b0, 1'b1, 4'b0001, 2'd0, 16'h2222};
    vecs[6]  = '{1'b1, 2'd0, 16'h1111, 1'b0, 2'd0, 16'h2222, 1'b1, 1'b0, 4'b0001, 2'd0, 16'h1111};
    vecs[7]  = '{1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 4'b0000, 2'd0, 16'h1111};
    vecs[8]  = '{1'b0, 2'd0, 16'h0000, 1'b1, 2'd1, 16'h0101, 1'b0, 1'b1, 4'b0010, 2'd1, 16'h0101};
    vecs[9]  = '{1'b0, 2'd0, 16'h0000, 1'b1, 2'd2, 16'h0202, 1'b0, 1'b1, 4'b0100, 2'd2, 16'h0202};
    vecs[10] = '{1'b0, 2'd0, 16'h0000, 1'b1, 2'd3, 16'h0303, 1'b0, 1'b1, 4'b1000, 2'd3, 16'h0303};
    vecs[11] = '{1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 4'b0000, 2'd3, 16'h0303};

    resetPulse();

    // A request held from reset release waits out the NREG clearing cycles.
    applyStimulus(1'b1, 2'd2, 16'h1234, 1'b0, '0, '0);
    for (int k = 1; k <= NREG; k++) begin
      @(posedge CLK);
      #1;
      checkOutput("init_wr_en", 32'(wr_en), 32'(1) << (k - 1));
      checkOutput("init_wr_data", 32'(wr_data), 32'h0);
      checkOutput("init_done", 32'(init_done), (k == NREG) ? 32'h1 : 32'h0);
      checkOutput("init_a_gnt", 32'(a_gnt), (k == NREG) ? 32'h1 : 32'h0);
    end
    @(posedge CLK);
    #1;
    checkOutput("first_wr_en", 32'(wr_en), 32'b0100);
    checkOutput("first_wr_addr", 32'(wr_addr), 32'd2);
    checkOutput("first_wr_data", 32'(wr_data), 32'h1234);

    // Reset lands while a fresh write is granted; the write must be lost.
    applyStimulus(1'b1, 2'd3, 16'hBEEF, 1'b0, '0, '0);
    #1;
    checkOutput("inflight_a_gnt", 32'(a_gnt), 32'h1);
    resetPulse();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    @(posedge CLK);
    #1;
    checkOutput("restart_wr_en", 32'(wr_en), 32'b0001);
    checkOutput("restart_wr_data", 32'(wr_data), 32'h0);
    checkOutput("restart_init_done", 32'(init_done), 32'h0);
    for (int k = 2; k <= NREG; k++) begin
      @(posedge CLK);
      #1;
    end
    checkOutput("restart_done", 32'(init_done), 32'h1);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].ar, vecs[i].aa, vecs[i].ad, vecs[i].br, vecs[i].ba, vecs[i].bd);
      @(negedge CLK);
      checkOutput($sformatf("vec%0d_a_gnt", i), 32'(a_gnt), 32'(vecs[i].ga));
      checkOutput($sformatf("vec%0d_b_gnt", i), 32'(b_gnt), 32'(vecs[i].gb));
      @(posedge CLK);
      #1;
      checkOutput($sformatf("vec%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].en));
      checkOutput($sformatf("vec%0d_wr_addr", i), 32'(wr_addr), 32'(vecs[i].addr));
      checkOutput($sformatf("vec%0d_wr_data", i), 32'(wr_data), 32'(vecs[i].data));
    end

    // Random traffic obeying the hold-until-granted handshake, with
    // occasional abandoned requests and one mid-run reset.
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    resetPulse();
    for (int n = 0; n < 400; n++) begin
      stepCycle();
      if (n == 200) begin
        resetPulse();
      end else begin
        if (!a_req || last_ga || $urandom_range(7) == 0) begin
          a_req  = ($urandom_range(3) != 0);
          a_addr = AW'($urandom);
          a_data = DATA_W'($urandom);
        end
        if (!b_req || last_gb || $urandom_range(7) == 0) begin
          b_req  = ($urandom_range(3) != 0);
          b_addr = AW'($urandom);
          b_data = DATA_W'($urandom);
        end
      end
    end
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    stepCycle();
    for (int i = 0; i < NREG; i++) begin
      checkOutput($sformatf("bank%0d", i), 32'(obs_bank[i]), 32'(exp_bank[i]));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
